// File: rtl/cpu_step_pkg.sv
// Purpose: shared types and constants for the CPU step controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state type, default debounce length, debounce counter width helper.
package cpu_step_pkg;

    typedef enum logic [1:0] {
        HALT      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        BREAK     = 2'd3
    } step_state_t;

    // 20 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // The counter only has to reach cycles-1, so clog2(cycles) bits suffice.
    function automatic int debounce_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Purpose: synchronize a raw pushbutton, debounce it, emit a one-cycle press pulse.
// Latency: press rises 2 + DEBOUNCE_CYCLES cycles after a clean button edge.
// Backpressure: none; presses not consumed by the caller are simply lost.
// Ports: iclk, reset (sync, active-high), btn (raw, async), press (one-cycle pulse).
module btn_debounce
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic iclk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_m;
    logic          btn_s;
    logic          btn_db;
    logic          btn_db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge iclk) begin
        if (reset) begin
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            cnt      <= '0;
        end else begin
            btn_m    <= btn;
            btn_s    <= btn_m;
            btn_db_q <= btn_db;
            // Count consecutive cycles the synchronized level disagrees with
            // the accepted level; any agreement restarts the count.
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_db <= btn_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Purpose: turn the divided tick level into one-cycle CPU advance enables (run or single-step).
// Latency: cpu_en one cycle after the qualifying tick rise; step_count one cycle after cpu_en.
// Backpressure: none; presses arriving while a step is pending or while running are dropped.
// Ports: iclk, reset (sync, active-high), tick, btn_step, sw_run -> cpu_en, halted, step_count.
// Optional: define BREAKPOINT_EN to add pc, bp_addr, bp_valid and the BREAK state.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic             iclk,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_step,
    input  logic             sw_run,
`ifdef BREAKPOINT_EN
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
`endif
    output logic             cpu_en,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    logic        tick_q;
    logic        tick_rise;
    logic        run_m;
    logic        run_s;
    logic        press;
    logic        bp_hit;
    logic        cpu_en_nxt;
    logic        halted_nxt;
    step_state_t state;
    step_state_t state_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .iclk  (iclk),
        .reset (reset),
        .btn   (btn_step),
        .press (press)
    );

    // tick_q clears on reset, so a high tick in the first cycle counts as a rise.
    assign tick_rise = tick & ~tick_q;

`ifdef BREAKPOINT_EN
    assign bp_hit = bp_valid & (pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // State register plus registered outputs.
    always_ff @(posedge iclk) begin
        if (reset) begin
            tick_q     <= 1'b0;
            run_m      <= 1'b0;
            run_s      <= 1'b0;
            state      <= HALT;
            cpu_en     <= 1'b0;
            halted     <= 1'b1;
            step_count <= '0;
        end else begin
            tick_q <= tick;
            run_m  <= sw_run;
            run_s  <= run_m;
            state  <= state_nxt;
            cpu_en <= cpu_en_nxt;
            halted <= halted_nxt;
            if (cpu_en) begin
                step_count <= step_count + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            HALT: begin
                // The run switch wins over a simultaneous press.
                if (run_s) begin
                    state_nxt = RUN;
                end else if (press) begin
                    state_nxt = STEP_WAIT;
                end
            end
            RUN: begin
`ifdef BREAKPOINT_EN
                if (tick_rise && bp_hit) begin
                    state_nxt = BREAK;
                end else if (!run_s) begin
                    state_nxt = HALT;
                end
`else
                if (!run_s) begin
                    state_nxt = HALT;
                end
`endif
            end
            // run_s is deliberately ignored until the step has been issued.
            STEP_WAIT: begin
                if (tick_rise) begin
                    state_nxt = HALT;
                end
            end
`ifdef BREAKPOINT_EN
            BREAK: begin
                if (!run_s) begin
                    state_nxt = HALT;
                end
            end
`endif
            default: state_nxt = HALT;
        endcase
    end

    // Output decode: cpu_en follows the current state, so a tick rise on the
    // same cycle RUN drops to HALT still advances the CPU.
    always_comb begin
        cpu_en_nxt = 1'b0;
        halted_nxt = (state_nxt != RUN);
        case (state)
            RUN:       cpu_en_nxt = tick_rise & ~bp_hit;
            STEP_WAIT: cpu_en_nxt = tick_rise;
            default:   cpu_en_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Purpose: self-checking bench for cpu_step_ctrl (table vectors, hand sequences, random vs model).
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_step_ctrl;

    localparam int DB  = 4;
    localparam int CW  = 8;
    localparam int MOD = 1 << CW;
    localparam int M_HALT = 0, M_RUN = 1, M_WAIT = 2, M_BREAK = 3;

    logic          iclk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          btn_step = 1'b0;
    logic          sw_run = 1'b0;
    logic          cpu_en;
    logic          halted;
    logic [CW-1:0] step_count;
`ifdef BREAKPOINT_EN
    logic [31:0]   pc = 32'h0;
    logic [31:0]   bp_addr = 32'h0;
    logic          bp_valid = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .iclk       (iclk),
        .reset      (reset),
        .tick       (tick),
        .btn_step   (btn_step),
        .sw_run     (sw_run),
`ifdef BREAKPOINT_EN
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
`endif
        .cpu_en     (cpu_en),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 iclk = ~iclk;

    // ---------------- behavioural reference model ----------------
    bit m_bpipe[2];
    bit m_rpipe[2];
    bit m_tick_prev;
    bit m_db;
    bit m_db_prev;
    bit m_win[$];   // synchronized button samples since reset, newest last
    int m_mode;
    bit m_en;
    bit m_halted;
    int m_count;

    task automatic model_reset();
        m_bpipe[0] = 0; m_bpipe[1] = 0;
        m_rpipe[0] = 0; m_rpipe[1] = 0;
        m_tick_prev = 0;
        m_db = 0; m_db_prev = 0;
        m_win.delete();
        m_mode = M_HALT;
        m_en = 0; m_halted = 1; m_count = 0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit bs, rs, rise, press, hit, en_n, all_diff;
        int mode_n;
        if (reset) begin
            model_reset();
            return;
        end
        bs    = m_bpipe[1];
        rs    = m_rpipe[1];
        rise  = tick && !m_tick_prev;
        press = m_db && !m_db_prev;
`ifdef BREAKPOINT_EN
        hit = bp_valid && (pc == bp_addr);
`else
        hit = 0;
`endif
        en_n = 0;
        mode_n = m_mode;
        case (m_mode)
            M_HALT: if (rs) mode_n = M_RUN; else if (press) mode_n = M_WAIT;
            M_RUN: begin
                if (rise && !hit) en_n = 1;
                if (rise && hit) mode_n = M_BREAK;
                else if (!rs) mode_n = M_HALT;
            end
            M_WAIT: if (rise) begin en_n = 1; mode_n = M_HALT; end
            default: if (!rs) mode_n = M_HALT;
        endcase
        if (m_en) m_count = (m_count + 1) % MOD;
        // A new level is accepted once the last DB samples all disagree with the old one.
        m_win.push_back(bs);
        if (m_win.size() > DB) void'(m_win.pop_front());
        m_db_prev = m_db;
        if (m_win.size() == DB) begin
            all_diff = 1;
            foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 0;
            if (all_diff) m_db = bs;
        end
        m_bpipe[1] = m_bpipe[0]; m_bpipe[0] = btn_step;
        m_rpipe[1] = m_rpipe[0]; m_rpipe[0] = sw_run;
        m_tick_prev = tick;
        m_en = en_n;
        m_mode = mode_n;
        m_halted = (mode_n != M_RUN);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge iclk);
        #1;
        if (cpu_en === 1'b1) n_pulses++;
        check("cpu_en", {31'b0, cpu_en}, {31'b0, m_en});
        check("halted", {31'b0, halted}, {31'b0, m_halted});
        check("step_count", {24'b0, step_count}, m_count);
    endtask

    task automatic rises(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            repeat (3) step();
            tick = 1'b0;
            repeat (3) step();
        end
    endtask

    function automatic bit btn_at(input int mode, input int k);
        case (mode)
            1:       return k < 10;
            2:       return (k < 20) && ((k / 2) % 2 == 0);
            3:       return (k < 10) || (k >= 20 && k < 30);
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        string name;
        bit    run;
        int    btn_mode;
        int    settle;
        int    n_rises;
        int    exp_pulses;
        bit    exp_halted;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0, c0, need, hold;
        vecs[0] = '{"run10",           1, 0, 10, 10, 10, 0};
        vecs[1] = '{"halt_idle",       0, 0, 10,  3,  0, 1};
        vecs[2] = '{"step_hold",       0, 1, 20,  3,  1, 1};
        vecs[3] = '{"bounce",          0, 2, 30,  3,  0, 1};
        vecs[4] = '{"double_req",      0, 3, 40,  3,  1, 1};
        vecs[5] = '{"run_ignores_btn", 1, 1, 20,  4,  4, 0};
        vecs[6] = '{"halt_again",      0, 0, 10,  2,  0, 1};
        model_reset();

        // Reset with every input active: nothing may escape.
        reset = 1'b1; sw_run = 1'b1; btn_step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick = ((k / 3) % 2) == 0;
            step();
            check("rst_no_en", {31'b0, cpu_en}, 32'd0);
        end
        check("rst_halted", {31'b0, halted}, 32'd1);
        check("rst_count", {24'b0, step_count}, 32'd0);
        reset = 1'b0; sw_run = 1'b0; btn_step = 1'b0; tick = 1'b0;
        repeat (4) step();

        // halted drops exactly three edges after the switch changes.
        sw_run = 1'b1;
        step(); step();
        check("halt_lat2", {31'b0, halted}, 32'd1);
        step();
        check("halt_lat3", {31'b0, halted}, 32'd0);
        sw_run = 1'b0;
        repeat (4) step();

        // Table-driven vectors.
        foreach (vecs[i]) begin
            p0 = n_pulses;
            c0 = m_count;
            sw_run = vecs[i].run;
            for (int k = 0; k < vecs[i].settle; k++) begin
                btn_step = btn_at(vecs[i].btn_mode, k);
                step();
            end
            btn_step = 1'b0;
            rises(vecs[i].n_rises);
            repeat (4) step();
            check({vecs[i].name, "_pulses"}, n_pulses - p0, vecs[i].exp_pulses);
            check({vecs[i].name, "_cnt"}, {24'b0, step_count},
                  (c0 + vecs[i].exp_pulses) % MOD);
            check({vecs[i].name, "_halted"}, {31'b0, halted}, {31'b0, vecs[i].exp_halted});
        end

        // Counter wrap.
        sw_run = 1'b1;
        repeat (4) step();
        need = (MOD - 1 - m_count + MOD) % MOD;
        rises(need);
        check("wrap_pre", {24'b0, step_count}, MOD - 1);
        rises(1);
        check("wrap", {24'b0, step_count}, 32'd0);

        // run_s falls in the same cycle as a tick rise: that advance still happens.
        p0 = n_pulses;
        sw_run = 1'b0;
        step(); step();
        tick = 1'b1;
        step();
        check("simul_en", {31'b0, cpu_en}, 32'd1);
        check("simul_halt", {31'b0, halted}, 32'd1);
        repeat (2) step();
        tick = 1'b0;
        repeat (3) step();
        rises(2);
        check("simul_pulses", n_pulses - p0, 32'd1);

        // Reset discards a pending step.
        p0 = n_pulses;
        btn_step = 1'b1; repeat (10) step();
        btn_step = 1'b0; repeat (10) step();
        reset = 1'b1; repeat (2) step();
        reset = 1'b0;
        check("rst_mid_cnt", {24'b0, step_count}, 32'd0);
        rises(2);
        check("rst_discard", n_pulses - p0, 32'd0);

        // Button held through reset release still yields one step.
        p0 = n_pulses;
        btn_step = 1'b1;
        reset = 1'b1; repeat (2) step();
        reset = 1'b0; repeat (12) step();
        btn_step = 1'b0; repeat (10) step();
        rises(2);
        check("held_reset_press", n_pulses - p0, 32'd1);

`ifdef BREAKPOINT_EN
        bp_addr = 32'h0040_0010; bp_valid = 1'b1; pc = 32'h0040_0000;
        p0 = n_pulses;
        sw_run = 1'b1; repeat (4) step();
        rises(2);
        check("bp_before", n_pulses - p0, 32'd2);
        pc = 32'h0040_0010;
        p0 = n_pulses;
        rises(1);
        check("bp_halted", {31'b0, halted}, 32'd1);
        btn_step = 1'b1; repeat (10) step();
        btn_step = 1'b0; repeat (10) step();
        rises(1);
        check("bp_suppress", n_pulses - p0, 32'd0);
        sw_run = 1'b0; repeat (4) step();
        btn_step = 1'b1; repeat (10) step();
        btn_step = 1'b0; repeat (10) step();
        rises(2);
        check("bp_step_past", n_pulses - p0, 32'd1);
`endif

        // Randomized traffic against the model.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) tick = ~tick;
            if (hold == 0) begin
                btn_step = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 10);
            end
            hold--;
            if ($urandom_range(0, 79) == 0) sw_run = ~sw_run;
            reset = ($urandom_range(0, 999) == 0);
`ifdef BREAKPOINT_EN
            pc = ($urandom_range(0, 3) == 0) ? bp_addr : bp_addr + 32'd4;
            bp_valid = 1'($urandom_range(0, 1));
`endif
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
